// File: rtl/dot_product_accumulator.sv
// ============================================================================
// Module      : dot_product_accumulator
// Description : Tags operand pairs entering a fixed-latency multiplier, sums the
//               returning products per vector, and queues finished dot products
//               in a 2-entry FWFT FIFO that is protected by input-side credits.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dot_product_accumulator #(
  parameter int MUL_LAT = 4,
  parameter int ACC_W   = 40,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [31:0]      prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam int c_ENT_W = ACC_W + 1 + CNT_W;

  localparam logic [0:0] c_ST_EMPTY   = 1'b0;
  localparam logic [0:0] c_ST_RUNNING = 1'b1;

  // --------------------------------------------------------------------------
  // Admission and tag delay line
  // --------------------------------------------------------------------------
  logic               w_accept;
  logic               w_accept_last;
  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic [MUL_LAT-1:0] lst_q, lst_d;
  logic               w_tap_vld;
  logic               w_tap_lst;

  assign w_accept      = in_valid & in_ready;
  assign w_accept_last = w_accept & in_last;

  generate
    if (MUL_LAT == 1) begin : g_dly_single
      assign vld_d = w_accept;
      assign lst_d = w_accept_last;
    end else begin : g_dly_multi
      assign vld_d = {vld_q[MUL_LAT-2:0], w_accept};
      assign lst_d = {lst_q[MUL_LAT-2:0], w_accept_last};
    end
  endgenerate

  assign w_tap_vld = vld_q[MUL_LAT-1];
  assign w_tap_lst = lst_q[MUL_LAT-1] & w_tap_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= vld_d;
      lst_q <= lst_d;
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator
  // --------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W:0]   w_sum;

  assign w_prod_ext = ACC_W'(prod);
  assign w_sum      = {1'b0, acc_q} + {1'b0, w_prod_ext};

  // acc_d/ovf_d/cnt_d are the post-step values; they also form the FIFO push word
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (w_tap_vld) begin
      if (state_q == c_ST_EMPTY) begin
        acc_d = w_prod_ext;
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = w_sum[ACC_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | w_sum[ACC_W];
      end
      state_d = w_tap_lst ? c_ST_EMPTY : c_ST_RUNNING;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_ST_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Credits: lasts accepted but not yet at the tap
  // --------------------------------------------------------------------------
  logic [1:0] infl_q, infl_d;

  always_comb begin
    infl_d = infl_q;
    case ({w_accept_last, w_tap_lst})
      2'b10:   infl_d = infl_q + 2'd1;
      2'b01:   infl_d = infl_q - 2'd1;
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q <= '0;
    end else begin
      infl_q <= infl_d;
    end
  end

  // --------------------------------------------------------------------------
  // Result FIFO, 2 entries, first-word fall-through
  // --------------------------------------------------------------------------
  logic [c_ENT_W-1:0] fifo0_q, fifo0_d;
  logic [c_ENT_W-1:0] fifo1_q, fifo1_d;
  logic [1:0]         fcnt_q, fcnt_d;
  logic [1:0]         w_rem;
  logic               w_push;
  logic               w_pop;
  logic [c_ENT_W-1:0] w_push_data;

  assign w_push      = w_tap_lst;
  assign w_pop       = (fcnt_q != 2'd0) & out_ready;
  assign w_push_data = {acc_d, ovf_d, cnt_d};
  assign w_rem       = fcnt_q - {1'b0, w_pop};

  // Credits keep w_rem below 2 whenever a push arrives
  always_comb begin
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    if (w_pop) begin
      fifo0_d = fifo1_q;
    end
    if (w_push) begin
      if (w_rem == 2'd0) begin
        fifo0_d = w_push_data;
      end else begin
        fifo1_d = w_push_data;
      end
    end
    fcnt_d = w_rem + {1'b0, w_push};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo0_q <= '0;
      fifo1_q <= '0;
      fcnt_q  <= '0;
    end else begin
      fifo0_q <= fifo0_d;
      fifo1_q <= fifo1_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid                     = (fcnt_q != 2'd0);
  assign {out_data, out_ovf, out_count} = fifo0_q;
  assign in_ready = ({1'b0, fcnt_q} + {1'b0, infl_q}) < 3'd2;

endmodule

`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
// ============================================================================
// Module      : tb_dot_product_accumulator
// Description : Directed and scoreboarded bench with a behavioural 4-cycle multiplier.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dot_product_accumulator;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] prod;
  logic [31:0] mp [MUL_LAT];

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Free-running multiplier model
  always_ff @(posedge clk) begin
    mp[0] <= {16'b0, a} * {16'b0, b};
    for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
  end
  assign prod = mp[MUL_LAT-1];

  logic        iv0, il0, rdy0, ov0, ovf0;
  logic [39:0] od0;
  logic [7:0]  oc0;
  logic        iv1, il1, rdy1, ov1, ovf1;
  logic [32:0] od1;
  logic [7:0]  oc1;

  assign iv0 = in_valid & ~sel;
  assign il0 = in_last  & ~sel;
  assign iv1 = in_valid & sel;
  assign il1 = in_last  & sel;

  dot_product_accumulator #(.MUL_LAT(MUL_LAT), .ACC_W(40), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_last(il0), .in_ready(rdy0),
    .prod(prod), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_ovf(ovf0), .out_count(oc0)
  );

  dot_product_accumulator #(.MUL_LAT(MUL_LAT), .ACC_W(33), .CNT_W(8)) dut33 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_last(il1), .in_ready(rdy1),
    .prod(prod), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_ovf(ovf1), .out_count(oc1)
  );

  logic        rdy, ov, oovf;
  logic [39:0] od;
  logic [7:0]  oc;
  assign rdy  = sel ? rdy1 : rdy0;
  assign ov   = sel ? ov1  : ov0;
  assign oovf = sel ? ovf1 : ovf0;
  assign od   = sel ? {7'b0, od1} : od0;
  assign oc   = sel ? oc1  : oc0;

  typedef struct {
    logic [39:0] d;
    logic        o;
    logic [7:0]  c;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic l);
    a = x;
    b = y;
    in_valid = 1'b1;
    in_last = l;
    chk("send_ready", rdy, 1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!ov && n < 30) begin
      tick();
      n++;
    end
    chk(tag, ov, 1);
  endtask

  task automatic chk_res(input string tag, input logic [39:0] d, input logic o, input logic [7:0] c);
    chk({tag, "_data"}, od, d);
    chk({tag, "_ovf"}, oovf, o);
    chk({tag, "_count"}, oc, c);
  endtask

  initial begin
    logic [63:0] msum;
    int          mcnt;
    logic        acc, pop;
    exp_t        e;

    // Reset values
    repeat (2) tick();
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_out_ovf", oovf, 0);
    chk("rst_out_count", oc, 0);
    chk("rst_in_ready", rdy, 1);
    rst = 1'b0;
    tick();

    // Three-term vector and exact latency
    send(3, 4, 0);
    send(5, 6, 0);
    send(7, 8, 1);
    repeat (3) tick();
    chk("t1_early_valid", ov, 0);
    tick();
    chk("t1_valid", ov, 1);
    chk_res("t1", 40'd98, 1'b0, 8'd3);
    tick();
    chk("t1_popped", ov, 0);

    // Single full-scale term followed by back-to-back vector
    send(16'hFFFF, 16'hFFFF, 1);
    send(2, 2, 0);
    send(3, 3, 1);
    wait_out("t2a_valid");
    chk_res("t2a", 40'hFFFE0001, 1'b0, 8'd1);
    tick();
    wait_out("t2b_valid");
    chk_res("t2b", 40'd13, 1'b0, 8'd2);
    tick();

    // Term counter wraps modulo 256
    for (int i = 0; i < 256; i++) send(1, 1, 0);
    send(1, 1, 1);
    wait_out("wrap_valid");
    chk_res("wrap", 40'd257, 1'b0, 8'd1);
    tick();

    // Backpressure and credit stall
    out_ready = 1'b0;
    send(1, 1, 1);
    send(2, 2, 1);
    chk("t3_ready_drop", rdy, 0);
    a = 3; b = 3; in_valid = 1'b1; in_last = 1'b1;
    repeat (8) tick();
    chk("t3_still_blocked", rdy, 0);
    chk("t3_head_valid", ov, 1);
    chk_res("t3_head1", 40'd1, 1'b0, 8'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_ready_after_pop", rdy, 1);
    chk_res("t3_head2", 40'd4, 1'b0, 8'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t3_ready_again_low", rdy, 0);
    repeat (6) tick();
    chk_res("t3_head2_held", 40'd4, 1'b0, 8'd1);
    out_ready = 1'b1;
    tick();
    chk_res("t3_head3", 40'd9, 1'b0, 8'd1);
    tick();
    chk("t3_drained", ov, 0);

    // 33-bit accumulator overflow
    sel = 1'b1;
    send(16'hFFFF, 16'hFFFF, 0);
    send(16'hFFFF, 16'hFFFF, 1);
    wait_out("t4a_valid");
    chk_res("t4a", 40'h1FFFC0002, 1'b0, 8'd2);
    tick();
    for (int i = 0; i < 2; i++) send(16'hFFFF, 16'hFFFF, 0);
    send(16'hFFFF, 16'hFFFF, 1);
    wait_out("t4b_valid");
    chk_res("t4b", 40'h0FFFA0003, 1'b1, 8'd3);
    tick();
    send(1, 1, 1);
    wait_out("t4c_valid");
    chk_res("t4c", 40'd1, 1'b0, 8'd1);
    tick();
    sel = 1'b0;

    // Asynchronous reset mid-vector with a result pending
    out_ready = 1'b0;
    send(5, 5, 1);
    wait_out("t5_pre_valid");
    send(1, 2, 0);
    a = 3; b = 4; in_valid = 1'b1; in_last = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", ov, 0);
    chk("t5_rst_data", od, 0);
    chk("t5_rst_count", oc, 0);
    chk("t5_rst_ready", rdy, 1);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("t5_no_stale", ov, 0);
    send(1, 1, 0);
    send(2, 2, 1);
    wait_out("t5_valid");
    chk_res("t5", 40'd5, 1'b0, 8'd2);
    tick();

    // Random traffic against a transaction-level scoreboard, then drain
    msum = '0;
    mcnt = 0;
    for (int i = 0; i < 10020; i++) begin
      if (i < 10000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_last   = ($urandom_range(0, 4) == 0);
        out_ready = ($urandom_range(0, 2) != 0);
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
      end else begin
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
      end
      chk("sb_ready_rule", rdy, (q.size() < 2));
      acc = in_valid & rdy;
      pop = ov & out_ready;
      if (pop) begin
        chk("sb_unexpected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk_res("sb", e.d, e.o, e.c);
        end
      end
      if (acc) begin
        msum = msum + ({48'b0, a} * {48'b0, b});
        mcnt++;
        if (in_last) begin
          e.d = msum[39:0];
          e.o = (msum[63:40] != 0);
          e.c = mcnt[7:0];
          q.push_back(e);
          msum = '0;
          mcnt = 0;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    chk("sb_lost", q.size(), 0);
    chk("sb_final_empty", ov, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
